// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin N_REQ-to-1 byte arbiter for a UART transmitter (req_valid/req_data/req_ready in, tx_send_go/tx_data/tx_time_set/tx_done out, busy/grant_id/timeout_err status)
module uart_tx_arbiter #(
  parameter int N_REQ = 4,
  parameter int GAP_CYC = 0,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic                     sys_clk,
  input  logic                     rst,
  input  logic [2:0]               cfg_baud,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [8*N_REQ-1:0]       req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     tx_send_go,
  output logic [7:0]               tx_data,
  output logic [2:0]               tx_time_set,
  input  logic                     tx_done,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     timeout_err
);
  localparam int GW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT_CYC + GAP_CYC + 1);
  localparam logic [1:0] IDLE = 2'd0, LAUNCH = 2'd1, WAIT = 2'd2, GAP = 2'd3;
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [GW-1:0] sel, cand;
  logic found;
  always_comb begin
    sel = '0;
    cand = '0;
    found = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = GW'((int'(grant_id) + k) % N_REQ);
      if (req_valid[cand]) begin
        sel = cand;
        found = 1'b1;
      end
    end
  end
  assign busy = state != IDLE;
  assign tx_send_go = state == LAUNCH;
  assign req_ready = (!rst && state == IDLE && found) ? N_REQ'(1) << sel : '0;
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      tx_data <= 8'h00;
      tx_time_set <= 3'd2;
      grant_id <= GW'(N_REQ - 1);
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          tx_time_set <= cfg_baud;
          cnt <= '0;
          if (found) begin
            tx_data <= req_data[8*sel +: 8];
            grant_id <= sel;
            state <= LAUNCH;
          end
        end
        LAUNCH: begin
          cnt <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (tx_done) begin
            cnt <= '0;
            state <= (GAP_CYC > 0) ? GAP : IDLE;
          end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
            timeout_err <= 1'b1;
            cnt <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (cnt == CW'(GAP_CYC - 1)) begin
            cnt <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized scoreboard bench for uart_tx_arbiter against a cycle-stamp reference model
module tb_uart_tx_arbiter;
  localparam int N = 4, GAP = 5, TO = 50;
  logic sys_clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] cfg_baud = 3'd2;
  logic [N-1:0] req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0] req_ready;
  logic tx_send_go;
  logic [7:0] tx_data;
  logic [2:0] tx_time_set;
  logic tx_done = 1'b0;
  logic busy;
  logic [1:0] grant_id;
  logic timeout_err;
  int total = 0, bad = 0, cyc = 0;
  logic [7:0] q[N][$];
  bit drop_mode = 0, rnd_baud = 0;
  int tx_mode = 0;
  typedef struct {int id; logic [7:0] data;} exp_t;
  exp_t exp_q[$];
  exp_t e;
  uart_tx_arbiter #(.N_REQ(N), .GAP_CYC(GAP), .TIMEOUT_CYC(TO)) dut (
    .sys_clk(sys_clk), .rst(rst), .cfg_baud(cfg_baud), .req_valid(req_valid),
    .req_data(req_data), .req_ready(req_ready), .tx_send_go(tx_send_go),
    .tx_data(tx_data), .tx_time_set(tx_time_set), .tx_done(tx_done),
    .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
  );
  always #5 sys_clk = ~sys_clk;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] ex);
    total++;
    if (got !== ex) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, ex);
    end
  endtask
  function automatic int qsum();
    int s = 0;
    for (int i = 0; i < N; i++) s += q[i].size();
    return s;
  endfunction
  bit m_idle = 1;
  int m_last = N - 1, go_at = -1, ws = -1, idle_at = -1, to_at = -1, pick;
  logic [2:0] m_baud = 3'd2;
  logic [N-1:0] er;
  always @(negedge sys_clk) begin
    cyc++;
    if (rst) begin
      chk("rst_ready", req_ready, 0);
      chk("rst_go", tx_send_go, 0);
      chk("rst_busy", busy, 0);
      chk("rst_terr", timeout_err, 0);
      chk("rst_tset", tx_time_set, 2);
      m_idle = 1; m_last = N - 1; go_at = -1; ws = -1; idle_at = -1; to_at = -1; m_baud = 3'd2;
    end else begin
      if (!m_idle && idle_at == cyc) m_idle = 1;
      chk("timeout_err", timeout_err, to_at == cyc);
      chk("tx_send_go", tx_send_go, go_at == cyc);
      chk("busy", busy, !m_idle);
      chk("tx_time_set", tx_time_set, m_baud);
      pick = -1;
      if (m_idle)
        for (int k = 1; k <= N; k++)
          if (pick < 0 && req_valid[(m_last + k) % N]) pick = (m_last + k) % N;
      er = '0;
      if (pick >= 0) er[pick] = 1'b1;
      chk("req_ready", req_ready, er);
      if (m_idle) m_baud = cfg_baud;
      if (pick >= 0) begin
        exp_q.push_back('{pick, req_data[8*pick +: 8]});
        m_last = pick; m_idle = 0; go_at = cyc + 1; ws = cyc + 2;
      end else if (ws >= 0 && cyc >= ws) begin
        if (tx_done) begin
          idle_at = cyc + 1 + GAP; ws = -1;
        end else if (cyc - ws == TO - 1) begin
          to_at = cyc + 1; idle_at = cyc + 1; ws = -1;
        end
      end
    end
  end
  logic [7:0] cur_d = 8'h00;
  int cur_id = N - 1;
  always @(negedge sys_clk) begin
    if (rst) begin
      exp_q.delete();
      cur_d = 8'h00; cur_id = N - 1;
    end else if (tx_send_go) begin
      if (exp_q.size() == 0) chk("go_unexpected", 1, 0);
      else begin
        e = exp_q.pop_front();
        cur_d = e.data; cur_id = e.id;
      end
    end
    chk("tx_data", tx_data, cur_d);
    chk("grant_id", grant_id, cur_id);
  end
  initial begin : drv
    logic [N-1:0] hs;
    forever begin
      @(negedge sys_clk);
      hs = req_ready & req_valid;
      @(posedge sys_clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (hs[i] && q[i].size() > 0) void'(q[i].pop_front());
        req_valid[i] = q[i].size() > 0 && (!drop_mode || $urandom_range(0, 3) != 0);
        req_data[8*i +: 8] = q[i].size() > 0 ? q[i][0] : 8'($urandom);
      end
      if (rnd_baud && $urandom_range(0, 7) == 0) cfg_baud = 3'($urandom_range(0, 2));
    end
  end
  initial begin : xmit
    int d;
    forever begin
      @(negedge sys_clk);
      if (tx_send_go && !rst && tx_mode != 1) begin
        d = tx_mode == 2 ? TO - 1 : tx_mode == 3 ? TO : $urandom_range(0, 6);
        @(posedge sys_clk); #1;
        repeat (d) begin @(posedge sys_clk); #1; end
        tx_done = 1'b1;
        @(posedge sys_clk); #1;
        tx_done = 1'b0;
        if (tx_mode == 0 && $urandom_range(0, 1) == 1) begin
          @(posedge sys_clk); #1; tx_done = 1'b1;
          @(posedge sys_clk); #1; tx_done = 1'b0;
        end
      end
    end
  end
  task automatic drain();
    int n = 0;
    @(negedge sys_clk);
    while ((qsum() > 0 || busy) && n < 3000) begin
      @(negedge sys_clk);
      n++;
    end
    if (n >= 3000) chk("drain_timeout", 1, 0);
    repeat (4) @(negedge sys_clk);
    @(posedge sys_clk); #1;
  endtask
  initial begin
    int n;
    repeat (3) @(negedge sys_clk);
    @(posedge sys_clk); #1;
    rst = 1'b0;
    for (int i = 0; i < N; i++) repeat (2) q[i].push_back(8'($urandom));
    drain();
    q[2].push_back(8'hA5);
    drain();
    tx_mode = 2;
    q[1].push_back(8'h3C);
    repeat (10) @(posedge sys_clk);
    #1 cfg_baud = 3'd0;
    drain();
    cfg_baud = 3'd2;
    tx_mode = 1;
    q[3].push_back(8'h77);
    drain();
    tx_mode = 3;
    q[0].push_back(8'h88);
    drain();
    tx_mode = 0; drop_mode = 1; rnd_baud = 1;
    repeat (12) begin
      for (int i = 0; i < N; i++) repeat ($urandom_range(0, 3)) q[i].push_back(8'($urandom));
      drain();
    end
    drop_mode = 0; rnd_baud = 0;
    tx_mode = 1;
    q[1].push_back(8'h11);
    q[3].push_back(8'h33);
    n = 0;
    @(negedge sys_clk);
    while (!tx_send_go && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    chk("go_seen", tx_send_go, 1);
    repeat (5) @(posedge sys_clk);
    #1 rst = 1'b1;
    q[0].push_back(8'h5A);
    repeat (2) @(posedge sys_clk);
    #1 rst = 1'b0;
    tx_mode = 0;
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
